jag_dram_responder: RTL and testbench
=====================================

Name: jag_dram_responder

Overview:
- DRAM-side responder for the memory controller's RAS/CAS strobe interface.
- Decodes the controller's active-low bank selects (rasl), casl, byte write enables (wel) and oel, plus the multiplexed row/column address.
- Converts each CAS cycle into a single-word request to a backing memory over a req/ack handshake.
- Drives read data back onto the controller data bus.
- Sits between the Jaguar MEM block and the board SDRAM arbiter. It is the receiving end of the chip-select signals the RAS generator produces.

Parameters:
ADDR_W, 10, width of the multiplexed row/column address (maddr)
DATA_W, 64, data bus width; byte lanes = DATA_W/8
BANKS, 2, number of rasl bank selects (1..4)

Ports:
sys_clk  in  1  single system clock; all logic on posedge
resl  in  1  asynchronous active-low reset
rasl  in  BANKS  active-low row strobes, one per bank (synchronous to sys_clk)
casl  in  1  active-low column strobe
wel  in  DATA_W/8  active-low byte write enables, sampled at CAS fall
oel  in  1  active-low output enable
maddr  in  ADDR_W  multiplexed row/column address
din  in  DATA_W  write data from controller
dout  out  DATA_W  read data to controller
dout_en  out  1  high when dout must be driven onto the bus
mem_req  out  1  backing-memory request
mem_we  out  1  1 = write, 0 = read
mem_be  out  DATA_W/8  active-high byte enables
mem_addr  out  clog2(BANKS)+2*ADDR_W  {bank,row,col}
mem_wdata  out  DATA_W  write data
mem_rdata  in  DATA_W  read data, valid in the ack cycle
mem_ack  in  1  request accepted/completed
conflict  out  1  sticky: two banks opened simultaneously or while a row is open

Behaviour:
- Reset is asynchronous and active-low on resl.
  - All outputs go to 0, state IDLE, registered strobes go to 1.
  - Reset mid-request drops mem_req immediately. The arbiter treats that as an abort.
- Edge detection: rasl/casl are registered each cycle. A fall is "prev=1 & now=0"; a rise is "prev=0 & now=1". There is no other synchronisation.
- States:
  - IDLE → ROW on any rasl bit fall.
    - Lowest bank index wins and its bank and row=maddr are latched.
    - If more than one bank falls in the same cycle, set conflict.
  - ROW → REQ on casl fall.
    - Latch col=maddr.
    - mem_we = ~&wel and mem_be = ~wel; if read, mem_be = all ones.
    - mem_wdata = din.
    - mem_req rises the cycle after the fall is detected (one-cycle latency).
  - REQ: hold mem_req and all mem_* fields stable until mem_ack=1.
    - mem_req drops the cycle after ack.
    - On a read, dout <= mem_rdata in the ack cycle.
    - Next state is HOLD.
  - HOLD → ROW on casl rise. This is page mode; the row stays open for further CAS cycles.
  - A rise of the open bank's rasl in ROW or HOLD → IDLE.
  - A rise of the open bank's rasl in REQ: the request is not aborted. Set a close-pending flag and go to IDLE after ack.
  - Any other bank falling while not in IDLE is ignored and sets conflict.
- dout_en = (state==HOLD) & ~mem_we & ~oel & ~casl. dout holds its last value otherwise.
- A CAS fall while casl was already low is impossible by definition of edge. A CAS fall in IDLE or REQ is ignored.
- Simultaneous RAS rise and CAS fall in ROW: the RAS rise wins and no request is issued.
- mem_addr is built as {bank, row, col} with bank zero-extended to clog2(BANKS) bits (min 1).

Optional Feature:
- Macro: JAG_CBR_REFRESH_EN.
- Defined:
  - A rasl fall while casl is already low (CAS-before-RAS) is a refresh.
  - Enter state RFSH, issue no mem_req, and return to IDLE on that rasl rise.
  - An 8-bit rfsh_cnt output port exists and increments per refresh, wrapping 255→0.
- Not defined:
  - No RFSH state and no rfsh_cnt port.
  - That RAS fall opens a row normally. Because the CAS edge already passed, no access occurs until the next CAS fall.

Test Plan:
- Read: rasl=2'b10 with maddr=0x155, then casl fall with maddr=0x0AA and oel=0; ack after 3 cycles with mem_rdata=0x0123456789ABCDEF → mem_addr={1'b0,10'h155,10'h0AA}, mem_we=0, mem_be=8'hFF, dout_en=1 with dout=0x0123456789ABCDEF until casl rises.
- Byte write: wel=8'hFC with din=0xDEAD_BEEF_0000_1234 on bank 1 → mem_we=1, mem_be=8'h03, mem_wdata equals din; ack with no delay → mem_req is high for exactly 1 cycle.
- Page mode: one RAS cycle containing 4 CAS cycles with cols 0..3 → 4 requests, all with the same row, cols 0,1,2,3.
- rasl rises during REQ before ack → mem_req held until ack; IDLE the cycle after ack; no further requests.
- Both rasl bits fall in the same cycle → bank 0 opened and conflict=1; conflict stays 1 until resl is pulsed low.
- JAG_CBR_REFRESH_EN: casl low, then rasl[0] falls, then rasl[0] rises, repeated 256 times → zero mem_req pulses and rfsh_cnt wraps back to 0.

Source files
------------

// File: rtl/jag_dram_responder_if.sv
// Strobe-side and backing-memory-side signal bundle for jag_dram_responder.
// The rfsh_cnt signal exists only when JAG_CBR_REFRESH_EN is defined.
interface jag_dram_responder_if #(
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned DATA_W = 64,
   parameter int unsigned BANKS  = 2
);
   localparam int unsigned BE_W   = DATA_W / 8;
   localparam int unsigned BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1;
   localparam int unsigned MA_W   = BANK_W + 2 * ADDR_W;

   logic [BANKS-1:0]  rasl;
   logic              casl;
   logic [BE_W-1:0]   wel;
   logic              oel;
   logic [ADDR_W-1:0] maddr;
   logic [DATA_W-1:0] din;
   logic [DATA_W-1:0] dout;
   logic              dout_en;
   logic              mem_req;
   logic              mem_we;
   logic [BE_W-1:0]   mem_be;
   logic [MA_W-1:0]   mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;
   logic              conflict;
`ifdef JAG_CBR_REFRESH_EN
   logic [7:0]        rfsh_cnt;
`endif

   modport slave (
      input  rasl, casl, wel, oel, maddr, din, mem_rdata, mem_ack,
      output dout, dout_en, mem_req, mem_we, mem_be, mem_addr, mem_wdata, conflict
`ifdef JAG_CBR_REFRESH_EN
      , output rfsh_cnt
`endif
   );

   modport master (
      output rasl, casl, wel, oel, maddr, din, mem_rdata, mem_ack,
      input  dout, dout_en, mem_req, mem_we, mem_be, mem_addr, mem_wdata, conflict
`ifdef JAG_CBR_REFRESH_EN
      , input rfsh_cnt
`endif
   );
endinterface

// File: rtl/jag_dram_responder.sv
// DRAM-side responder: turns RAS/CAS strobe cycles into single-word req/ack memory accesses.
// Optional CAS-before-RAS refresh (RFSH state, rfsh_cnt) is enabled by JAG_CBR_REFRESH_EN.
module jag_dram_responder #(
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned DATA_W = 64,
   parameter int unsigned BANKS  = 2
) (
   input  logic                  sys_clk,
   input  logic                  resl,
   jag_dram_responder_if.slave   bus
);
   localparam int unsigned BE_W   = DATA_W / 8;
   localparam int unsigned BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1;
   localparam int unsigned MA_W   = BANK_W + 2 * ADDR_W;

   typedef enum logic [2:0] {
      IDLE,
      ROW,
      REQ,
      HOLD
`ifdef JAG_CBR_REFRESH_EN
      , RFSH
`endif
   } state_t;

   state_t            state_q, state_n;
   logic [BANKS-1:0]  ras_q;
   logic              cas_q;
   logic [BANK_W-1:0] bank_q, bank_n;
   logic [ADDR_W-1:0] row_q, row_n;
   logic              close_q, close_n;
   logic              mem_req_q, mem_req_n;
   logic              mem_we_q, mem_we_n;
   logic [BE_W-1:0]   mem_be_q, mem_be_n;
   logic [MA_W-1:0]   mem_addr_q, mem_addr_n;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_n;
   logic [DATA_W-1:0] dout_q, dout_n;
   logic              conflict_q, conflict_n;
`ifdef JAG_CBR_REFRESH_EN
   logic [7:0]        rfsh_q, rfsh_n;
`endif

   logic [BANKS-1:0]  ras_fall, ras_rise, open_mask;
   logic              cas_fall, cas_rise, open_rise, fall_multi, wr;
   logic [BANK_W-1:0] fall_bank;

   // Edge detection against last cycle's registered strobes
   assign ras_fall   = ras_q & ~bus.rasl;
   assign ras_rise   = ~ras_q & bus.rasl;
   assign cas_fall   = cas_q & ~bus.casl;
   assign cas_rise   = ~cas_q & bus.casl;
   assign open_mask  = BANKS'(1) << bank_q;
   assign open_rise  = |(ras_rise & open_mask);
   assign fall_multi = (ras_fall & (ras_fall - BANKS'(1))) != '0;
   assign wr         = ~&bus.wel;

   always_comb begin
      fall_bank = '0;
      for (int i = int'(BANKS) - 1; i >= 0; i--) begin
         if (ras_fall[i]) fall_bank = BANK_W'(i);
      end
   end

   always_ff @(posedge sys_clk or negedge resl) begin
      if (!resl) begin
         state_q     <= IDLE;
         ras_q       <= '1;
         cas_q       <= 1'b1;
         bank_q      <= '0;
         row_q       <= '0;
         close_q     <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_be_q    <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         dout_q      <= '0;
         conflict_q  <= 1'b0;
`ifdef JAG_CBR_REFRESH_EN
         rfsh_q      <= '0;
`endif
      end else begin
         state_q     <= state_n;
         ras_q       <= bus.rasl;
         cas_q       <= bus.casl;
         bank_q      <= bank_n;
         row_q       <= row_n;
         close_q     <= close_n;
         mem_req_q   <= mem_req_n;
         mem_we_q    <= mem_we_n;
         mem_be_q    <= mem_be_n;
         mem_addr_q  <= mem_addr_n;
         mem_wdata_q <= mem_wdata_n;
         dout_q      <= dout_n;
         conflict_q  <= conflict_n;
`ifdef JAG_CBR_REFRESH_EN
         rfsh_q      <= rfsh_n;
`endif
      end
   end

   always_comb begin
      state_n     = state_q;
      bank_n      = bank_q;
      row_n       = row_q;
      close_n     = close_q;
      mem_req_n   = mem_req_q;
      mem_we_n    = mem_we_q;
      mem_be_n    = mem_be_q;
      mem_addr_n  = mem_addr_q;
      mem_wdata_n = mem_wdata_q;
      dout_n      = dout_q;
      conflict_n  = conflict_q;
`ifdef JAG_CBR_REFRESH_EN
      rfsh_n      = rfsh_q;
`endif

      // Any other bank opening while a row (or refresh) is active is ignored but flagged
      if (state_q != IDLE && (ras_fall & ~open_mask) != '0) conflict_n = 1'b1;

      case (state_q)
         IDLE: begin
            if (ras_fall != '0) begin
               bank_n  = fall_bank;
               row_n   = bus.maddr;
               state_n = ROW;
               if (fall_multi) conflict_n = 1'b1;
`ifdef JAG_CBR_REFRESH_EN
               if (!cas_q) begin
                  state_n = RFSH;
                  rfsh_n  = rfsh_q + 8'd1;
               end
`endif
            end
         end
         ROW: begin
            // RAS close takes priority over a coincident CAS fall
            if (open_rise) begin
               state_n = IDLE;
            end else if (cas_fall) begin
               state_n     = REQ;
               mem_req_n   = 1'b1;
               mem_we_n    = wr;
               mem_be_n    = wr ? ~bus.wel : {BE_W{1'b1}};
               mem_addr_n  = {bank_q, row_q, bus.maddr};
               mem_wdata_n = bus.din;
            end
         end
         REQ: begin
            if (open_rise) close_n = 1'b1;
            if (bus.mem_ack) begin
               mem_req_n = 1'b0;
               close_n   = 1'b0;
               if (!mem_we_q) dout_n = bus.mem_rdata;
               state_n = (close_q || open_rise) ? IDLE : HOLD;
            end
         end
         HOLD: begin
            if (open_rise)     state_n = IDLE;
            else if (cas_rise) state_n = ROW;
         end
`ifdef JAG_CBR_REFRESH_EN
         RFSH: begin
            if (open_rise) state_n = IDLE;
         end
`endif
         default: state_n = IDLE;
      endcase
   end

   assign bus.dout      = dout_q;
   assign bus.dout_en   = (state_q == HOLD) & ~mem_we_q & ~bus.oel & ~bus.casl;
   assign bus.mem_req   = mem_req_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_be    = mem_be_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.conflict  = conflict_q;
`ifdef JAG_CBR_REFRESH_EN
   assign bus.rfsh_cnt  = rfsh_q;
`endif

endmodule

// File: tb/tb_jag_dram_responder.sv
// Self-checking bench for jag_dram_responder: randomized strobe cycles against a transaction-level model.
module tb_jag_dram_responder;
   localparam int unsigned ADDR_W = 10;
   localparam int unsigned DATA_W = 64;
   localparam int unsigned BANKS  = 2;
   localparam int unsigned BE_W   = DATA_W / 8;
   localparam int unsigned MA_W   = 1 + 2 * ADDR_W;
   localparam int unsigned TUP_W  = MA_W + 1 + BE_W + DATA_W;

   logic sys_clk = 1'b0;
   logic resl;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   req_pulses = 0;
   logic req_prev = 1'b0;

   // Results of the most recent access() call
   logic              a_got, a_we, a_stable, a_en, a_en_after;
   int                a_lat, a_req_cyc;
   logic [MA_W-1:0]   a_addr;
   logic [BE_W-1:0]   a_be;
   logic [DATA_W-1:0] a_wd, a_dout;

   jag_dram_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BANKS(BANKS)) bus ();

   jag_dram_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BANKS(BANKS)) dut (
      .sys_clk (sys_clk),
      .resl    (resl),
      .bus     (bus.slave)
   );

   always #5 sys_clk = ~sys_clk;

   always @(negedge sys_clk) begin
      if (bus.mem_req && !req_prev) req_pulses++;
      req_prev = bus.mem_req;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $fatal(1);
   end

   function automatic logic [MA_W-1:0] exp_addr(input int bank, input int row, input int col);
      return (MA_W'(bank) << (2 * ADDR_W)) | (MA_W'(row) << ADDR_W) | MA_W'(col);
   endfunction

   task automatic idle_inputs;
      bus.rasl = '1; bus.casl = 1'b1; bus.wel = '1; bus.oel = 1'b1;
      bus.maddr = '0; bus.din = '0; bus.mem_rdata = '0; bus.mem_ack = 1'b0;
   endtask

   task automatic do_reset;
      idle_inputs();
      resl = 1'b0;
      repeat (2) @(negedge sys_clk);
      resl = 1'b1;
      @(negedge sys_clk);
   endtask

   task automatic open_row(input logic [BANKS-1:0] r, input logic [ADDR_W-1:0] row);
      @(negedge sys_clk);
      bus.rasl = r; bus.maddr = row;
      @(negedge sys_clk);
   endtask

   task automatic close_row;
      @(negedge sys_clk);
      bus.rasl = '1;
      @(negedge sys_clk);
   endtask

   // One CAS cycle acting as controller and backing memory; records what the DUT did
   task automatic access(input logic [ADDR_W-1:0] col, input logic [BE_W-1:0] wel,
                         input logic [DATA_W-1:0] wdata, input int dly,
                         input logic [DATA_W-1:0] rdata);
      a_got = 0; a_lat = 0; a_addr = '0; a_we = 0; a_be = '0; a_wd = '0;
      a_req_cyc = 0; a_stable = 1; a_en = 0; a_dout = '0; a_en_after = 1;
      @(negedge sys_clk);
      bus.casl = 1'b0; bus.maddr = col; bus.wel = wel; bus.din = wdata; bus.oel = 1'b0;
      while (!a_got && a_lat < 8) begin
         @(negedge sys_clk);
         a_lat++;
         a_got = bus.mem_req;
      end
      if (a_got) begin
         a_addr = bus.mem_addr; a_we = bus.mem_we; a_be = bus.mem_be; a_wd = bus.mem_wdata;
         a_req_cyc = 1;
         bus.maddr = ADDR_W'($urandom); bus.din = {$urandom, $urandom}; bus.wel = BE_W'($urandom);
         for (int i = 0; i < dly; i++) begin
            @(negedge sys_clk);
            if (bus.mem_req) a_req_cyc++;
            if ({bus.mem_addr, bus.mem_we, bus.mem_be, bus.mem_wdata} !== {a_addr, a_we, a_be, a_wd})
               a_stable = 0;
         end
         bus.mem_ack = 1'b1; bus.mem_rdata = rdata;
         @(negedge sys_clk);
         bus.mem_ack = 1'b0; bus.mem_rdata = {$urandom, $urandom};
         if (bus.mem_req) a_req_cyc++;
         a_en = bus.dout_en; a_dout = bus.dout;
         @(negedge sys_clk);
         a_en = a_en & bus.dout_en;
         if (bus.dout !== a_dout) a_stable = 0;
      end
      bus.casl = 1'b1; bus.wel = '1;
      @(negedge sys_clk);
      a_en_after = bus.dout_en;
   endtask

   task automatic test_reset;
      logic [TUP_W+1:0] obs;
      idle_inputs();
      resl = 1'b0;
      repeat (2) @(negedge sys_clk);
      obs = {bus.dout_en, bus.mem_req, bus.mem_addr, bus.mem_we, bus.mem_be, bus.mem_wdata};
      n_checks++;
      if (obs !== '0 || bus.dout !== '0 || bus.conflict !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h dout=%h conflict=%b, expected all zero", obs, bus.dout, bus.conflict);
      end
      resl = 1'b1;
      repeat (3) @(negedge sys_clk);
      obs = {bus.dout_en, bus.mem_req, bus.mem_addr, bus.mem_we, bus.mem_be, bus.mem_wdata};
      n_checks++;
      if (obs !== '0 || req_pulses !== 0) begin
         n_fail++;
         $display("FAIL reset_release_idle: got %h pulses=%0d, expected zero and 0", obs, req_pulses);
      end
`ifdef JAG_CBR_REFRESH_EN
      n_checks++;
      if (bus.rfsh_cnt !== 8'd0) begin
         n_fail++;
         $display("FAIL reset_rfsh_cnt: got %0d, expected 0", bus.rfsh_cnt);
      end
`endif
   endtask

   task automatic test_read;
      logic [DATA_W-1:0] rd = 64'h0123456789ABCDEF;
      open_row(2'b10, 10'h155);
      access(10'h0AA, 8'hFF, {$urandom, $urandom}, 3, rd);
      n_checks++;
      if (!a_got || a_lat !== 1) begin
         n_fail++;
         $display("FAIL read_latency: got req=%b after %0d cycles, expected req after 1", a_got, a_lat);
      end
      n_checks++;
      if ({a_addr, a_we, a_be} !== {1'b0, 10'h155, 10'h0AA, 1'b0, 8'hFF}) begin
         n_fail++;
         $display("FAIL read_fields: got addr=%h we=%b be=%h, expected addr=%h we=0 be=ff",
                  a_addr, a_we, a_be, {1'b0, 10'h155, 10'h0AA});
      end
      n_checks++;
      if (a_req_cyc !== 4 || !a_stable) begin
         n_fail++;
         $display("FAIL read_req_hold: got %0d cycles stable=%b, expected 4 cycles stable=1", a_req_cyc, a_stable);
      end
      n_checks++;
      if ({a_en, a_dout, a_en_after} !== {1'b1, rd, 1'b0}) begin
         n_fail++;
         $display("FAIL read_dout: got en=%b dout=%h en_after_cas_rise=%b, expected en=1 dout=%h en_after=0",
                  a_en, a_dout, a_en_after, rd);
      end
      close_row();
   endtask

   task automatic test_byte_write;
      logic [DATA_W-1:0] wd = 64'hDEAD_BEEF_0000_1234;
      logic [ADDR_W-1:0] row = ADDR_W'($urandom);
      logic [ADDR_W-1:0] col = ADDR_W'($urandom);
      open_row(2'b01, row);
      access(col, 8'hFC, wd, 0, {$urandom, $urandom});
      n_checks++;
      if ({a_addr, a_we, a_be, a_wd} !== {exp_addr(1, row, col), 1'b1, 8'h03, wd}) begin
         n_fail++;
         $display("FAIL byte_write_fields: got addr=%h we=%b be=%h wdata=%h, expected addr=%h we=1 be=03 wdata=%h",
                  a_addr, a_we, a_be, a_wd, exp_addr(1, row, col), wd);
      end
      n_checks++;
      if (a_req_cyc !== 1 || a_en !== 1'b0) begin
         n_fail++;
         $display("FAIL byte_write_req_pulse: got %0d cycles dout_en=%b, expected 1 cycle dout_en=0", a_req_cyc, a_en);
      end
      close_row();
   endtask

   task automatic test_page_mode;
      int p0 = req_pulses;
      int bad = 0;
      int bank = $urandom_range(0, 1);
      logic [ADDR_W-1:0] row = ADDR_W'($urandom);
      logic [BE_W-1:0]   wel;
      logic [DATA_W-1:0] wd;
      logic              we;
      open_row(~(BANKS'(1) << bank), row);
      for (int c = 0; c < 4; c++) begin
         we  = 1'($urandom);
         wel = we ? (BE_W'($urandom) & 8'h7F) : 8'hFF;
         wd  = {$urandom, $urandom};
         access(ADDR_W'(c), wel, wd, $urandom_range(0, 3), {$urandom, $urandom});
         if ({a_addr, a_we, a_be, a_wd} !== {exp_addr(bank, row, c), we, (we ? ~wel : 8'hFF), wd}) bad++;
      end
      close_row();
      n_checks++;
      if (bad !== 0) begin
         n_fail++;
         $display("FAIL page_mode_fields: got %0d wrong requests, expected 0", bad);
      end
      n_checks++;
      if (req_pulses - p0 !== 4) begin
         n_fail++;
         $display("FAIL page_mode_count: got %0d requests, expected 4", req_pulses - p0);
      end
   endtask

   task automatic test_random;
      int p0 = req_pulses;
      int total = 0;
      int bad_fields = 0, bad_timing = 0, bad_dout = 0;
      int bank, dly;
      logic [ADDR_W-1:0] row, col;
      logic [BE_W-1:0]   wel;
      logic [DATA_W-1:0] wd, rd;
      logic              we;
      for (int t = 0; t < 8; t++) begin
         bank = $urandom_range(0, 1);
         row  = ADDR_W'($urandom);
         open_row(~(BANKS'(1) << bank), row);
         for (int k = $urandom_range(1, 3); k > 0; k--) begin
            col = ADDR_W'($urandom);
            we  = 1'($urandom);
            wel = we ? BE_W'($urandom) : 8'hFF;
            if (we && wel == 8'hFF) wel = 8'hFE;
            wd  = {$urandom, $urandom};
            rd  = {$urandom, $urandom};
            dly = $urandom_range(0, 4);
            access(col, wel, wd, dly, rd);
            total++;
            if ({a_addr, a_we, a_be, a_wd} !== {exp_addr(bank, row, col), we, (we ? ~wel : 8'hFF), wd})
               bad_fields++;
            if (a_lat !== 1 || a_req_cyc !== dly + 1 || !a_stable) bad_timing++;
            if (we ? (a_en !== 1'b0) : ({a_en, a_dout, a_en_after} !== {1'b1, rd, 1'b0})) bad_dout++;
         end
         close_row();
      end
      n_checks++;
      if (bad_fields !== 0) begin
         n_fail++;
         $display("FAIL random_fields: got %0d wrong of %0d, expected 0", bad_fields, total);
      end
      n_checks++;
      if (bad_timing !== 0) begin
         n_fail++;
         $display("FAIL random_timing: got %0d wrong of %0d, expected 0", bad_timing, total);
      end
      n_checks++;
      if (bad_dout !== 0) begin
         n_fail++;
         $display("FAIL random_dout: got %0d wrong of %0d, expected 0", bad_dout, total);
      end
      n_checks++;
      if (req_pulses - p0 !== total || bus.conflict !== 1'b0) begin
         n_fail++;
         $display("FAIL random_count: got %0d requests conflict=%b, expected %0d and 0",
                  req_pulses - p0, bus.conflict, total);
      end
   endtask

   task automatic test_ras_close_in_req;
      int p0 = req_pulses;
      logic [ADDR_W-1:0] row = ADDR_W'($urandom);
      logic [ADDR_W-1:0] col = ADDR_W'($urandom);
      logic [ADDR_W-1:0] row2 = ADDR_W'($urandom);
      logic [DATA_W-1:0] rd = {$urandom, $urandom};
      open_row(2'b10, row);
      @(negedge sys_clk);
      bus.casl = 1'b0; bus.maddr = col; bus.wel = '1; bus.oel = 1'b0;
      @(negedge sys_clk);
      bus.rasl = '1;
      repeat (3) @(negedge sys_clk);
      n_checks++;
      if ({bus.mem_req, bus.mem_addr} !== {1'b1, exp_addr(0, row, col)}) begin
         n_fail++;
         $display("FAIL close_in_req_hold: got req=%b addr=%h, expected req=1 addr=%h",
                  bus.mem_req, bus.mem_addr, exp_addr(0, row, col));
      end
      bus.mem_ack = 1'b1; bus.mem_rdata = rd;
      @(negedge sys_clk);
      bus.mem_ack = 1'b0;
      n_checks++;
      if ({bus.mem_req, bus.dout_en, bus.dout} !== {1'b0, 1'b0, rd}) begin
         n_fail++;
         $display("FAIL close_in_req_idle: got req=%b dout_en=%b dout=%h, expected 0 0 %h",
                  bus.mem_req, bus.dout_en, bus.dout, rd);
      end
      bus.casl = 1'b1;
      @(negedge sys_clk);
      bus.casl = 1'b0;
      repeat (4) @(negedge sys_clk);
      bus.casl = 1'b1;
      @(negedge sys_clk);
      n_checks++;
      if (req_pulses - p0 !== 1) begin
         n_fail++;
         $display("FAIL close_in_req_count: got %0d requests, expected 1", req_pulses - p0);
      end
      open_row(2'b01, row2);
      access(col, 8'hFF, '0, 1, rd);
      close_row();
      n_checks++;
      if (a_addr !== exp_addr(1, row2, col)) begin
         n_fail++;
         $display("FAIL close_in_req_reopen: got addr=%h, expected %h", a_addr, exp_addr(1, row2, col));
      end
   endtask

   task automatic test_ras_beats_cas;
      int p0 = req_pulses;
      open_row(2'b01, ADDR_W'($urandom));
      @(negedge sys_clk);
      bus.rasl = '1; bus.casl = 1'b0; bus.maddr = ADDR_W'($urandom);
      repeat (5) @(negedge sys_clk);
      bus.casl = 1'b1;
      @(negedge sys_clk);
      n_checks++;
      if (req_pulses - p0 !== 0) begin
         n_fail++;
         $display("FAIL ras_beats_cas: got %0d requests, expected 0", req_pulses - p0);
      end
   endtask

   task automatic test_cbr;
      int p0;
      do_reset();
      p0 = req_pulses;
      @(negedge sys_clk);
      bus.casl = 1'b0;
      for (int i = 1; i <= 256; i++) begin
         @(negedge sys_clk);
         bus.rasl = 2'b10;
         @(negedge sys_clk);
         bus.rasl = '1;
         @(negedge sys_clk);
`ifdef JAG_CBR_REFRESH_EN
         if (i == 1 || i == 255) begin
            n_checks++;
            if (bus.rfsh_cnt !== 8'(i % 256)) begin
               n_fail++;
               $display("FAIL cbr_count_%0d: got %0d, expected %0d", i, bus.rfsh_cnt, i % 256);
            end
         end
`endif
      end
      bus.casl = 1'b1;
      repeat (2) @(negedge sys_clk);
      n_checks++;
      if (req_pulses - p0 !== 0) begin
         n_fail++;
         $display("FAIL cbr_no_request: got %0d requests, expected 0", req_pulses - p0);
      end
`ifdef JAG_CBR_REFRESH_EN
      n_checks++;
      if (bus.rfsh_cnt !== 8'd0) begin
         n_fail++;
         $display("FAIL cbr_wrap: got %0d, expected 0", bus.rfsh_cnt);
      end
`endif
   endtask

   task automatic test_conflict;
      logic [ADDR_W-1:0] row = ADDR_W'($urandom);
      logic [ADDR_W-1:0] col = ADDR_W'($urandom);
      do_reset();
      open_row(2'b00, row);
      n_checks++;
      if (bus.conflict !== 1'b1) begin
         n_fail++;
         $display("FAIL conflict_dual_fall: got %b, expected 1", bus.conflict);
      end
      access(col, 8'hFF, '0, 0, {$urandom, $urandom});
      n_checks++;
      if (a_addr !== exp_addr(0, row, col)) begin
         n_fail++;
         $display("FAIL conflict_bank0_wins: got addr=%h, expected %h", a_addr, exp_addr(0, row, col));
      end
      close_row();
      repeat (3) @(negedge sys_clk);
      n_checks++;
      if (bus.conflict !== 1'b1) begin
         n_fail++;
         $display("FAIL conflict_sticky: got %b, expected 1", bus.conflict);
      end
      do_reset();
      open_row(2'b01, row);
      n_checks++;
      if (bus.conflict !== 1'b0) begin
         n_fail++;
         $display("FAIL conflict_cleared: got %b, expected 0", bus.conflict);
      end
      @(negedge sys_clk);
      bus.rasl = 2'b00;
      @(negedge sys_clk);
      access(col, 8'hFF, '0, 0, {$urandom, $urandom});
      n_checks++;
      if ({bus.conflict, a_addr} !== {1'b1, exp_addr(1, row, col)}) begin
         n_fail++;
         $display("FAIL conflict_second_bank: got conflict=%b addr=%h, expected 1 %h",
                  bus.conflict, a_addr, exp_addr(1, row, col));
      end
      close_row();
      do_reset();
   endtask

   task automatic test_reset_abort;
      open_row(2'b10, ADDR_W'($urandom));
      @(negedge sys_clk);
      bus.casl = 1'b0; bus.maddr = ADDR_W'($urandom); bus.wel = 8'h00; bus.din = {$urandom, $urandom};
      @(negedge sys_clk);
      #2 resl = 1'b0;
      #1;
      n_checks++;
      if (bus.mem_req !== 1'b0 || bus.mem_we !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_abort: got req=%b we=%b, expected 0 0 before next clock", bus.mem_req, bus.mem_we);
      end
      @(negedge sys_clk);
      idle_inputs();
      @(negedge sys_clk);
      resl = 1'b1;
      repeat (2) @(negedge sys_clk);
   endtask

   initial begin
      test_reset();
      test_read();
      test_byte_write();
      test_page_mode();
      test_random();
      test_ras_close_in_req();
      test_ras_beats_cas();
      test_cbr();
      test_conflict();
      test_reset_abort();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
